cpu_run_ctrl: RTL and testbench

// Run/step/breakpoint controller for the single-cycle RISC-V core on the FPGA board.

---
 rtl/cpu_run_ctrl_if.sv | 41 ++++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
// Bundle between the board-side button/debug logic plus the core's PC, and the
// run/step/breakpoint controller.
//
// Signals:
//   btn_run, btn_step, btn_halt : debounced button levels
//   bp_en, bp_addr              : breakpoint enable and address
//   pc                          : core's current PC (instruction about to execute)
//   cpu_en                      : core enable, one instruction commits per clk when 1
//   state_o                     : 00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   halted                      : 1 in HALT or BREAK
//   instr_cnt                   : number of cycles with cpu_en = 1
//
// Modports:
//   master : board/core side, drives buttons, breakpoint and pc
//   slave  : the controller itself
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             btn_run;
    logic             btn_step;
    logic             btn_halt;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic [1:0]       state_o;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output btn_run, btn_step, btn_halt, bp_en, bp_addr, pc,
        input  cpu_en, state_o, halted, instr_cnt
    );

    modport slave (
        input  btn_run, btn_step, btn_halt, bp_en, bp_addr, pc,
        output cpu_en, state_o, halted, instr_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step/breakpoint controller for the single-cycle RISC-V core. Turns the
// debounced board buttons and the core's PC into the clock-enable that gates
// PC, register-file and memory writes.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : cpu_run_ctrl_if.slave (buttons, breakpoint, pc in; cpu_en, state_o,
//         halted, instr_cnt out)
//
// The PC_W and CNT_W parameters must match the ones given to the interface.
module cpu_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);

    localparam int SC_W = $clog2(STEP_CYCLES + 1);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             prevRun_q, prevStep_q, prevHalt_q;
    logic             skip_q, skip_d;
    logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic runRise, stepRise, haltRise, hit, cpuEn;

    assign runRise  = bus.btn_run  & ~prevRun_q;
    assign stepRise = bus.btn_step & ~prevStep_q;
    assign haltRise = bus.btn_halt & ~prevHalt_q;

    // skip masks the breakpoint on the first RUN cycle so a run can resume
    // from the very address it broke on.
    assign hit = bus.bp_en & (PC_W'(bus.pc) == PC_W'(bus.bp_addr)) & ~skip_q;

    // Prev-button flops come out of reset at 1 so a button that is already
    // held when reset releases is not mistaken for a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HALT;
            prevRun_q   <= 1'b1;
            prevStep_q  <= 1'b1;
            prevHalt_q  <= 1'b1;
            skip_q      <= 1'b0;
            step_cnt_q  <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prevRun_q   <= bus.btn_run;
            prevStep_q  <= bus.btn_step;
            prevHalt_q  <= bus.btn_halt;
            skip_q      <= skip_d;
            step_cnt_q  <= step_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Next state and the Mealy core enable. Halt wins over run, run over step.
    // A halt press suppresses the commit in the same cycle it is seen.
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        step_cnt_d = step_cnt_q;
        cpuEn      = 1'b0;
        case (state_q)
            HALT: begin
                if (!haltRise) begin
                    if (runRise) begin
                        state_d = RUN;
                        skip_d  = 1'b1;
                    end else if (stepRise) begin
                        state_d    = STEP;
                        step_cnt_d = '0;
                    end
                end
            end
            RUN: begin
                cpuEn  = ~hit & ~haltRise;
                skip_d = 1'b0;
                if (haltRise) begin
                    state_d = HALT;
                end else if (hit) begin
                    state_d = BRK;
                end
            end
            STEP: begin
                cpuEn = ~haltRise;
                if (haltRise) begin
                    state_d = HALT;
                end else begin
                    step_cnt_d = step_cnt_q + SC_W'(1);
                    if (step_cnt_q == STEP_LAST) begin
                        state_d = HALT;
                    end
                end
            end
            BRK: begin
                if (haltRise) begin
                    state_d = HALT;
                end else if (runRise) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (stepRise) begin
                    state_d    = STEP;
                    step_cnt_d = '0;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
        instr_cnt_d = cpuEn ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    end

    assign bus.cpu_en    = cpuEn;
    assign bus.state_o   = state_q;
    assign bus.halted    = (state_q == HALT) || (state_q == BRK);
    assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. dutA uses STEP_CYCLES=1, CNT_W=32 and has a
// tiny core model that advances pc by 4 on every enabled cycle; dutB uses
// STEP_CYCLES=3, CNT_W=4 for multi-cycle steps and counter wrap.
module tb_cpu_run_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ifA ();
    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(4))  ifB ();

    cpu_run_ctrl #(.PC_W(32), .STEP_CYCLES(1), .CNT_W(32)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    cpu_run_ctrl #(.PC_W(32), .STEP_CYCLES(3), .CNT_W(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // One clock: the core model behind dutA commits (pc += 4) whenever
    // cpu_en was high going into the edge.
    task automatic applyStimulus();
        logic en;
        #1;
        en = ifA.cpu_en;
        @(posedge clk);
        #1;
        if (en) ifA.pc = ifA.pc + 32'd4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ifA.btn_run = 1'b1;  ifA.btn_step = 1'b0; ifA.btn_halt = 1'b0;
        ifA.bp_en   = 1'b0;  ifA.bp_addr  = 32'd0; ifA.pc      = 32'd0;
        ifB.btn_run = 1'b0;  ifB.btn_step = 1'b0; ifB.btn_halt = 1'b0;
        ifB.bp_en   = 1'b0;  ifB.bp_addr  = 32'd0; ifB.pc      = 32'd0;

        // T1: btn_run held across reset release must not start a run
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("T1 state", ifA.state_o, 2'b00);
        checkOutput("T1 cpu_en", ifA.cpu_en, 1'b0);
        checkOutput("T1 instr_cnt", ifA.instr_cnt, 32'd0);
        checkOutput("T1 halted", ifA.halted, 1'b1);
        checkOutput("T1 B instr_cnt", ifB.instr_cnt, 4'd0);
        ifA.btn_run = 1'b0;

        // T2: single step from HALT
        ifA.btn_step = 1'b1;
        settle();
        checkOutput("T2 no en on press", ifA.cpu_en, 1'b0);
        applyStimulus();
        ifA.btn_step = 1'b0;
        settle();
        checkOutput("T2 state STEP", ifA.state_o, 2'b10);
        checkOutput("T2 cpu_en", ifA.cpu_en, 1'b1);
        applyStimulus();
        settle();
        checkOutput("T2 back HALT", ifA.state_o, 2'b00);
        checkOutput("T2 cpu_en low", ifA.cpu_en, 1'b0);
        checkOutput("T2 instr_cnt", ifA.instr_cnt, 32'd1);

        // T3: run from pc=0 into a breakpoint at 0x10
        ifA.pc      = 32'd0;
        ifA.bp_en   = 1'b1;
        ifA.bp_addr = 32'h10;
        ifA.btn_run = 1'b1;
        applyStimulus();
        ifA.btn_run = 1'b0;
        settle();
        checkOutput("T3 state RUN", ifA.state_o, 2'b01);
        checkOutput("T3 cpu_en", ifA.cpu_en, 1'b1);
        repeat (4) applyStimulus();
        settle();
        checkOutput("T3 pc at bp", ifA.pc, 32'h10);
        checkOutput("T3 hit blocks en", ifA.cpu_en, 1'b0);
        applyStimulus();
        settle();
        checkOutput("T3 state BREAK", ifA.state_o, 2'b11);
        checkOutput("T3 halted", ifA.halted, 1'b1);
        checkOutput("T3 instr_cnt", ifA.instr_cnt, 32'd5);

        // T4a: resume with run; first cycle at 0x10 must commit
        ifA.btn_run = 1'b1;
        applyStimulus();
        ifA.btn_run = 1'b0;
        settle();
        checkOutput("T4 skip commits", ifA.cpu_en, 1'b1);
        applyStimulus();
        settle();
        checkOutput("T4 run continues", ifA.state_o, 2'b01);
        checkOutput("T4 pc", ifA.pc, 32'h14);
        ifA.bp_addr = 32'h18;
        applyStimulus();
        settle();
        checkOutput("T4 second hit", ifA.cpu_en, 1'b0);
        applyStimulus();
        settle();
        checkOutput("T4 state BREAK", ifA.state_o, 2'b11);

        // T4b: step off the breakpoint executes exactly one instruction
        ifA.btn_step = 1'b1;
        applyStimulus();
        ifA.btn_step = 1'b0;
        settle();
        checkOutput("T4 step state", ifA.state_o, 2'b10);
        checkOutput("T4 step en at bp", ifA.cpu_en, 1'b1);
        applyStimulus();
        settle();
        checkOutput("T4 step HALT", ifA.state_o, 2'b00);
        checkOutput("T4 step instr_cnt", ifA.instr_cnt, 32'd8);
        checkOutput("T4 step pc", ifA.pc, 32'h1C);

        // T5: halt and run rising together while running
        ifA.btn_run = 1'b1;
        applyStimulus();
        ifA.btn_run = 1'b0;
        applyStimulus();
        ifA.btn_halt = 1'b1;
        ifA.btn_run  = 1'b1;
        settle();
        checkOutput("T5 halt blocks en", ifA.cpu_en, 1'b0);
        applyStimulus();
        settle();
        checkOutput("T5 state HALT", ifA.state_o, 2'b00);
        checkOutput("T5 instr_cnt", ifA.instr_cnt, 32'd9);
        ifA.btn_halt = 1'b0;
        ifA.btn_run  = 1'b0;

        // T5b: reset asserted mid-step drops cpu_en immediately
        ifA.btn_step = 1'b1;
        applyStimulus();
        ifA.btn_step = 1'b0;
        settle();
        checkOutput("T5 mid-step en", ifA.cpu_en, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("T5 rst cpu_en", ifA.cpu_en, 1'b0);
        checkOutput("T5 rst state", ifA.state_o, 2'b00);
        checkOutput("T5 rst halted", ifA.halted, 1'b1);
        checkOutput("T5 rst instr_cnt", ifA.instr_cnt, 32'd0);
        #3;
        rst = 1'b0;
        applyStimulus();

        // T2 with STEP_CYCLES=3: cpu_en high exactly three cycles
        ifB.btn_step = 1'b1;
        applyStimulus();
        ifB.btn_step = 1'b0;
        settle();
        checkOutput("T2B cycle1 en", ifB.cpu_en, 1'b1);
        applyStimulus();
        settle();
        checkOutput("T2B cycle2 en", ifB.cpu_en, 1'b1);
        checkOutput("T2B cycle2 state", ifB.state_o, 2'b10);
        applyStimulus();
        settle();
        checkOutput("T2B cycle3 en", ifB.cpu_en, 1'b1);
        applyStimulus();
        settle();
        checkOutput("T2B done en", ifB.cpu_en, 1'b0);
        checkOutput("T2B done state", ifB.state_o, 2'b00);
        checkOutput("T2B instr_cnt", ifB.instr_cnt, 4'd3);

        // T6: 4-bit counter runs up to 15 and wraps to 0
        ifB.btn_run = 1'b1;
        applyStimulus();
        ifB.btn_run = 1'b0;
        repeat (12) applyStimulus();
        settle();
        checkOutput("T6 cnt 15", ifB.instr_cnt, 4'd15);
        applyStimulus();
        settle();
        checkOutput("T6 cnt wrap", ifB.instr_cnt, 4'd0);
        checkOutput("T6 still RUN", ifB.state_o, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
